sma_window: RTL and testbench
=============================

SMA_WINDOW -- requirements
Module: sma_window

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits (signed two's complement), legal range 2..32.
REQ-002 SHALL have parameter LOG2_DEPTH, default 2, meaning window depth N = 2^LOG2_DEPTH samples, legal range 1..6.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port flush  input  1  meaning synchronous clear of window contents, active-high.
REQ-006 SHALL have port in_valid  input  1  meaning x carries a new sample this cycle.
REQ-007 SHALL have port x  input  DATA_W signed  meaning input sample.
REQ-008 SHALL have port out_valid  output  1  meaning y updated this cycle.
REQ-009 SHALL have port y  output  DATA_W signed  meaning registered window average.
REQ-010 SHALL have port primed  output  1  meaning at least N samples accepted since the last reset or flush.

Function
REQ-011 SHALL hold N sample registers in a circular buffer with write pointer wr_ptr (LOG2_DEPTH bits), all initialised to zero.
REQ-012 SHALL keep a running sum of width DATA_W+LOG2_DEPTH, equal at all times to the signed sum of the N buffer entries; no overflow possible.
REQ-013 On in_valid=1 (flush=0): buf[wr_ptr] <= x; sum <= sum + x - buf[wr_ptr]; wr_ptr <= wr_ptr+1, wrapping from N-1 to 0.
REQ-014 SHALL compute y from the updated sum (sum_next) by arithmetic right shift of LOG2_DEPTH bits, then take the low DATA_W bits; the result always fits without saturation.
REQ-015 SHALL register y and assert out_valid exactly one cycle after the accepting edge (latency 1); out_valid is a one-cycle pulse per accepted sample.
REQ-016 With in_valid=0: buffer, sum, wr_ptr and y SHALL hold; out_valid=0.
REQ-017 Back-to-back in_valid every cycle SHALL be accepted with no bubbles (throughput 1 sample/cycle).
REQ-018 A fill counter (saturating at N) SHALL increment per accepted sample; primed=1 once the count reaches N and stays 1 until reset or flush.
REQ-019 Before primed, y SHALL be the average computed with zeros in unfilled slots (divisor is always N).
REQ-020 flush=1 SHALL zero the buffer, sum, wr_ptr, fill count and primed on the next edge; y holds its value; out_valid=0.
REQ-021 flush=1 together with in_valid=1 SHALL take priority: the sample is discarded and out_valid=0 next cycle.

Reset
REQ-022 On a rising clk edge with rst=0: buffer, sum, wr_ptr and fill count SHALL be cleared to 0; outputs y=0, out_valid=0, primed=0.
REQ-023 Reset SHALL override flush and in_valid; a sample presented during reset is discarded.
REQ-024 Reset asserted mid-stream SHALL leave no residue: the first sample after release behaves as the first sample ever.

Configuration
REQ-025 Macro SMA_WINDOW_ROUND_EN defined: y = (sum_next + 2^(LOG2_DEPTH-1)) >>> LOG2_DEPTH (round half toward +infinity); the adder is one bit wider than sum so it cannot wrap.
REQ-026 Macro SMA_WINDOW_ROUND_EN undefined: y = sum_next >>> LOG2_DEPTH (floor); no rounding adder is instantiated.

Verification (DATA_W=16, LOG2_DEPTH=2, rounding off unless stated)
REQ-027 Hold rst=0 two cycles with in_valid=1, x=100 -> y=0, out_valid=0, primed=0 throughout; the first post-reset sample 4 gives y=1.
REQ-028 After reset, feed 4,8,12,16,20 on consecutive cycles -> y=1,3,6,10,14, one cycle after each; primed rises with the y=10 pulse.
REQ-029 From reset, feed x=-5 once -> y=-2; with SMA_WINDOW_ROUND_EN -> y=-1; feed x=6 once -> y=1, rounded y=2.
REQ-030 Feed four 32767 -> y=32767; then four -32768 -> final y=-32768, with no wrap at any step.
REQ-031 Feed 4,8 with three idle cycles between them -> y holds 1 during the gap with out_valid=0; then y=3.
REQ-032 Feed 40,40,40, then flush=1 together with in_valid=1, x=99 -> no out_valid, primed=0; next feed 8 -> y=2.

Source files
------------

// File: rtl/sma_window_if.sv
// Sample stream bundle for sma_window: flush/in_valid/x towards the filter,
// out_valid/y/primed back from it.
interface sma_window_if #(
   parameter int DATA_W = 16
);
   logic                     flush;
   logic                     in_valid;
   logic signed [DATA_W-1:0] x;
   logic                     out_valid;
   logic signed [DATA_W-1:0] y;
   logic                     primed;

   modport master (output flush, in_valid, x, input out_valid, y, primed);
   modport slave  (input flush, in_valid, x, output out_valid, y, primed);
endinterface

// File: rtl/sma_window.sv
// Simple moving average over the last 2^LOG2_DEPTH signed samples, latency 1.
// Optional rounding of the average selected by macro SMA_WINDOW_ROUND_EN (floor when undefined).
module sma_window #(
   parameter int DATA_W     = 16,
   parameter int LOG2_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   sma_window_if.slave  bus
);
   localparam int N     = 1 << LOG2_DEPTH;
   localparam int SUM_W = DATA_W + LOG2_DEPTH;
   localparam int CNT_W = LOG2_DEPTH + 1;

   logic signed [DATA_W-1:0] samples [N];
   logic [LOG2_DEPTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic signed [SUM_W-1:0]  sum_q, sum_d, sum_upd, x_ext, old_ext;
   logic [CNT_W-1:0]         fill_q, fill_d;
   logic                     primed_q, primed_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] y_q, y_d, avg;
   logic signed [DATA_W-1:0] oldest;
   logic                     accept;

   assign accept  = bus.in_valid && !bus.flush;
   assign oldest  = samples[wr_ptr_q];
   assign x_ext   = {{LOG2_DEPTH{bus.x[DATA_W-1]}}, bus.x};
   assign old_ext = {{LOG2_DEPTH{oldest[DATA_W-1]}}, oldest};
   // The slot being overwritten leaves the sum as the new sample enters it.
   assign sum_upd = sum_q + x_ext - old_ext;

`ifdef SMA_WINDOW_ROUND_EN
   localparam logic signed [SUM_W:0] HALF = (SUM_W+1)'(N / 2);
   logic signed [SUM_W:0] rnd_sum, rnd_shift;
   assign rnd_sum   = {sum_upd[SUM_W-1], sum_upd} + HALF;
   assign rnd_shift = rnd_sum >>> LOG2_DEPTH;
   assign avg       = rnd_shift[DATA_W-1:0];
`else
   logic signed [SUM_W-1:0] sum_shift;
   assign sum_shift = sum_upd >>> LOG2_DEPTH;
   assign avg       = sum_shift[DATA_W-1:0];
`endif

   for (genvar gi = 0; gi < N; gi++) begin : g_slot
      logic signed [DATA_W-1:0] slot_q, slot_d;

      always_comb begin
         slot_d = slot_q;
         if (bus.flush)
            slot_d = '0;
         else if (bus.in_valid && wr_ptr_q == LOG2_DEPTH'(gi))
            slot_d = bus.x;
      end

      always_ff @(posedge clk) begin
         if (!rst)
            slot_q <= '0;
         else
            slot_q <= slot_d;
      end

      assign samples[gi] = slot_q;
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      sum_d       = sum_q;
      fill_d      = fill_q;
      y_d         = y_q;
      out_valid_d = 1'b0;
      if (bus.flush) begin
         wr_ptr_d = '0;
         sum_d    = '0;
         fill_d   = '0;
      end else if (accept) begin
         wr_ptr_d    = wr_ptr_q + LOG2_DEPTH'(1);
         sum_d       = sum_upd;
         y_d         = avg;
         out_valid_d = 1'b1;
         if (fill_q != CNT_W'(N))
            fill_d = fill_q + CNT_W'(1);
      end
      // Fill only saturates and clears together with primed, so this is sticky.
      primed_d = (fill_d == CNT_W'(N));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         sum_q       <= '0;
         fill_q      <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         sum_q       <= sum_d;
         fill_q      <= fill_d;
         primed_q    <= primed_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.primed    = primed_q;
endmodule

// File: tb/tb_sma_window.sv
// Self-checking bench for sma_window (DATA_W=16, LOG2_DEPTH=2) using an expected-result queue.
module tb_sma_window;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sma_window_if #(.DATA_W(16)) bus ();

   sma_window #(.DATA_W(16), .LOG2_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   int                 m_buf [4];
   longint             m_sum;
   int                 m_ptr, m_fill;
   logic               exp_ov, exp_pr;
   logic signed [15:0] exp_y;
   logic signed [15:0] exp_q [$];
   logic signed [15:0] e;

   function automatic logic signed [15:0] model_avg(input longint s);
`ifdef SMA_WINDOW_ROUND_EN
      return 16'((s + 2) >>> 2);
`else
      return 16'(s >>> 2);
`endif
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_buf[i] = 0;
      m_sum  = 0;
      m_ptr  = 0;
      m_fill = 0;
      exp_pr = 1'b0;
   endtask

   // Drive one cycle of stimulus, advance the model, return just after the edge.
   task automatic step(input logic v, input int xv, input logic f, input logic r);
      @(negedge clk);
      rst = r; bus.in_valid = v; bus.x = 16'(xv); bus.flush = f;
      exp_ov = 1'b0;
      if (!r) begin
         model_clear();
         exp_y = '0;
         exp_q.delete();
      end else if (f) begin
         model_clear();
      end else if (v) begin
         m_sum = m_sum + longint'(xv) - longint'(m_buf[m_ptr]);
         m_buf[m_ptr] = xv;
         m_ptr = (m_ptr + 1) % 4;
         if (m_fill < 4) m_fill++;
         exp_pr = (m_fill == 4);
         exp_y  = model_avg(m_sum);
         exp_q.push_back(exp_y);
         exp_ov = 1'b1;
      end
      @(posedge clk);
      #1;
      $display("txn rst=%b flush=%b in_valid=%b x=%0d -> out_valid=%b y=%0d primed=%b",
               r, f, v, $signed(16'(xv)), bus.out_valid, bus.y, bus.primed);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 100, 1'b0, 1'b0);
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got %b want 0", bus.out_valid); end
         checks++; if (bus.y !== 16'sd0) begin errors++; $display("FAIL reset_y got %0d want 0", bus.y); end
         checks++; if (bus.primed !== 1'b0) begin errors++; $display("FAIL reset_primed got %b want 0", bus.primed); end
      end
      step(1'b1, 4, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_ov got %b want 1", bus.out_valid); end
      checks++; if (bus.y !== e || bus.y !== 16'sd1) begin errors++; $display("FAIL first_y got %0d want %0d", bus.y, e); end
   endtask

   task automatic test_ramp();
      int xs [5] = '{4, 8, 12, 16, 20};
      int ys [5] = '{1, 3, 6, 10, 14};
      step(1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, xs[i], 1'b0, 1'b1);
         e = exp_q.pop_front();
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ramp_ov[%0d] got %b want 1", i, bus.out_valid); end
         checks++; if (bus.y !== e || int'(bus.y) != ys[i]) begin errors++; $display("FAIL ramp_y[%0d] got %0d want %0d", i, bus.y, ys[i]); end
         checks++; if (bus.primed !== (i >= 3)) begin errors++; $display("FAIL ramp_primed[%0d] got %b want %b", i, bus.primed, i >= 3); end
      end
   endtask

   task automatic test_signs();
      int xs [2] = '{-5, 6};
`ifdef SMA_WINDOW_ROUND_EN
      int ys [2] = '{-1, 2};
`else
      int ys [2] = '{-2, 1};
`endif
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 0, 1'b0, 1'b0);
         step(1'b1, xs[i], 1'b0, 1'b1);
         e = exp_q.pop_front();
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sign_ov[%0d] got %b want 1", i, bus.out_valid); end
         checks++; if (bus.y !== e || int'(bus.y) != ys[i]) begin errors++; $display("FAIL sign_y[%0d] got %0d want %0d", i, bus.y, ys[i]); end
      end
   endtask

   task automatic test_extremes();
      step(1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, (i < 4) ? 32767 : -32768, 1'b0, 1'b1);
         e = exp_q.pop_front();
         checks++; if (bus.y !== e) begin errors++; $display("FAIL extreme_y[%0d] got %0d want %0d", i, bus.y, e); end
      end
      checks++; if (bus.y !== -16'sd32768) begin errors++; $display("FAIL extreme_final got %0d want -32768", bus.y); end
   endtask

   task automatic test_idle_gap();
      step(1'b0, 0, 1'b0, 1'b0);
      step(1'b1, 4, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++; if (bus.y !== e) begin errors++; $display("FAIL gap_first got %0d want %0d", bus.y, e); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 555, 1'b0, 1'b1);
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gap_ov[%0d] got %b want 0", i, bus.out_valid); end
         checks++; if (bus.y !== 16'sd1) begin errors++; $display("FAIL gap_hold[%0d] got %0d want 1", i, bus.y); end
      end
      step(1'b1, 8, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++; if (bus.y !== e || bus.y !== 16'sd3) begin errors++; $display("FAIL gap_second got %0d want 3", bus.y); end
   endtask

   task automatic test_flush();
      step(1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 40, 1'b0, 1'b1);
         e = exp_q.pop_front();
         checks++; if (bus.y !== e) begin errors++; $display("FAIL flush_pre_y[%0d] got %0d want %0d", i, bus.y, e); end
      end
      step(1'b1, 99, 1'b1, 1'b1);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ov got %b want 0", bus.out_valid); end
      checks++; if (bus.primed !== 1'b0) begin errors++; $display("FAIL flush_primed got %b want 0", bus.primed); end
      checks++; if (bus.y !== 16'sd30) begin errors++; $display("FAIL flush_hold got %0d want 30", bus.y); end
      step(1'b1, 8, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++; if (bus.y !== e || bus.y !== 16'sd2) begin errors++; $display("FAIL flush_after got %0d want 2", bus.y); end
   endtask

   task automatic test_back_to_back();
      logic signed [15:0] r16;
      step(1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         r16 = 16'($urandom);
         if (i == 15)      step(1'b1, 77, 1'b0, 1'b0);
         else if (i == 28) step(1'b1, int'(r16), 1'b1, 1'b1);
         else              step(1'b1, int'(r16), 1'b0, 1'b1);
         checks++; if (bus.out_valid !== exp_ov) begin errors++; $display("FAIL b2b_ov[%0d] got %b want %b", i, bus.out_valid, exp_ov); end
         checks++; if (bus.primed !== exp_pr) begin errors++; $display("FAIL b2b_primed[%0d] got %b want %b", i, bus.primed, exp_pr); end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (bus.y !== e) begin errors++; $display("FAIL b2b_y[%0d] got %0d want %0d", i, bus.y, e); end
         end else begin
            checks++; if (bus.y !== exp_y) begin errors++; $display("FAIL b2b_hold[%0d] got %0d want %0d", i, bus.y, exp_y); end
         end
      end
   endtask

   initial begin
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.x = '0;
      model_clear();
      exp_y = '0; exp_ov = 1'b0;
      test_reset();
      test_ramp();
      test_signs();
      test_extremes();
      test_idle_gap();
      test_flush();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
